// File: rtl/arm_mem_checker.sv
// End-of-program result checker: sweeps data memory against a golden memory once the PC leaves imem or the watchdog fires.
// Optional first-mismatch capture registers are built when ARM_CHECKER_CAPTURE_EN is defined.
module arm_mem_checker #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 64,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int PC_W           = 32,
    parameter int END_PC         = 128,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic [DATA_W-1:0] gold_rd_data,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_got,
    output logic [DATA_W-1:0] first_err_exp
);

    localparam int unsigned WD_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int unsigned CNT_W   = (WD_LAST > 0) ? $clog2(WD_LAST + 1) : 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic               r_rd_en;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_cmp_vld;
    logic               r_timeout;
    logic [ADDR_W:0]    r_err_count;
    logic               w_pc_end;
    logic               w_wd_hit;
    logic               w_last_addr;
    logic               w_mismatch;

    assign w_pc_end    = (pc >= PC_W'(END_PC));
    assign w_wd_hit    = (TIMEOUT_CYCLES != 0) && (r_cycle_cnt == CNT_W'(WD_LAST));
    assign w_last_addr = (r_rd_addr == ADDR_W'(DEPTH - 1));
    assign w_mismatch  = r_cmp_vld && (mem_rd_data != gold_rd_data);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN:   if (w_pc_end || w_wd_hit) w_next = S_SWEEP;
            S_SWEEP: if (w_last_addr) w_next = S_DRAIN;
            S_DRAIN: w_next = S_DONE;
            S_DONE:  w_next = S_DONE;
            default: w_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_cmp_vld   <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (r_state == S_RUN) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                r_rd_addr   <= '0;
                // A program that finishes on the watchdog cycle is not a timeout
                if (w_wd_hit && !w_pc_end) r_timeout <= 1'b1;
            end
            if (r_state == S_SWEEP && !w_last_addr) r_rd_addr <= r_rd_addr + ADDR_W'(1);
            r_rd_en   <= (w_next == S_SWEEP);
            r_cmp_vld <= r_rd_en;
            if (w_mismatch) r_err_count <= r_err_count + (ADDR_W + 1)'(1);
        end
    end

`ifdef ARM_CHECKER_CAPTURE_EN
    logic [ADDR_W-1:0] r_cmp_addr;
    logic [ADDR_W-1:0] r_first_addr;
    logic [DATA_W-1:0] r_first_got;
    logic [DATA_W-1:0] r_first_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_addr   <= '0;
            r_first_addr <= '0;
            r_first_got  <= '0;
            r_first_exp  <= '0;
        end else begin
            r_cmp_addr <= r_rd_addr;
            if (w_mismatch && (r_err_count == '0)) begin
                r_first_addr <= r_cmp_addr;
                r_first_got  <= mem_rd_data;
                r_first_exp  <= gold_rd_data;
            end
        end
    end

    assign first_err_addr = r_first_addr;
    assign first_err_got  = r_first_got;
    assign first_err_exp  = r_first_exp;
`else
    assign first_err_addr = '0;
    assign first_err_got  = '0;
    assign first_err_exp  = '0;
`endif

    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign timeout   = r_timeout;
    assign err_count = r_err_count;
    assign done      = (r_state == S_DONE);
    assign pass      = done && (r_err_count == '0) && !r_timeout;

endmodule

// File: tb/tb_arm_mem_checker.sv
// Scoreboard bench for arm_mem_checker: two instances (64x32 with a short watchdog, 16x16) behind synchronous memory models.
module tb_arm_mem_checker;

    localparam int DA   = 64;
    localparam int DB   = 16;
    localparam int TO_A = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [31:0] pc_a, pc_b;

    logic        rd_en_a, done_a, pass_a, to_a;
    logic [5:0]  rd_addr_a, faddr_a;
    logic [6:0]  err_a;
    logic [31:0] mdata_a, gdata_a, fgot_a, fexp_a;

    logic        rd_en_b, done_b, pass_b, to_b;
    logic [3:0]  rd_addr_b, faddr_b;
    logic [4:0]  err_b;
    logic [15:0] mdata_b, gdata_b, fgot_b, fexp_b;

    logic [31:0] mem_a [DA];
    logic [31:0] gold_a[DA];
    logic [15:0] mem_b [DB];
    logic [15:0] gold_b[DB];

    arm_mem_checker #(
        .DATA_W(32), .DEPTH(DA), .PC_W(32), .END_PC(128), .TIMEOUT_CYCLES(TO_A)
    ) dut_a (
        .clk(clk), .rst(rst_a), .pc(pc_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .mem_rd_data(mdata_a), .gold_rd_data(gdata_a), .done(done_a), .pass(pass_a),
        .timeout(to_a), .err_count(err_a), .first_err_addr(faddr_a),
        .first_err_got(fgot_a), .first_err_exp(fexp_a)
    );

    arm_mem_checker #(
        .DATA_W(16), .DEPTH(DB), .PC_W(32), .END_PC(64)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pc(pc_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .mem_rd_data(mdata_b), .gold_rd_data(gdata_b), .done(done_b), .pass(pass_b),
        .timeout(to_b), .err_count(err_b), .first_err_addr(faddr_b),
        .first_err_got(fgot_b), .first_err_exp(fexp_b)
    );

    always @(posedge clk) begin
        if (rd_en_a) begin
            mdata_a <= mem_a[rd_addr_a];
            gdata_a <= gold_a[rd_addr_a];
        end
        if (rd_en_b) begin
            mdata_b <= mem_b[rd_addr_b];
            gdata_b <= gold_b[rd_addr_b];
        end
    end

    bit          sel;
    logic        obs_done, obs_pass, obs_to, obs_rd_en;
    logic [31:0] obs_rd_addr, obs_err, obs_faddr, obs_fgot, obs_fexp;

    always_comb begin
        obs_done    = sel ? done_b  : done_a;
        obs_pass    = sel ? pass_b  : pass_a;
        obs_to      = sel ? to_b    : to_a;
        obs_rd_en   = sel ? rd_en_b : rd_en_a;
        obs_rd_addr = sel ? 32'(rd_addr_b) : 32'(rd_addr_a);
        obs_err     = sel ? 32'(err_b)     : 32'(err_a);
        obs_faddr   = sel ? 32'(faddr_b)   : 32'(faddr_a);
        obs_fgot    = sel ? 32'(fgot_b)    : fgot_a;
        obs_fexp    = sel ? 32'(fexp_b)    : fexp_a;
    end

    typedef struct {
        int          lat;
        int          err;
        int          faddr;
        logic [31:0] fgot;
        logic [31:0] fexp;
        bit          pass;
        bit          to;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] v);
        if (sel) pc_b = v;
        else     pc_a = v;
    endtask

    task automatic set_rst(input logic v);
        if (sel) rst_b = v;
        else     rst_a = v;
    endtask

    function automatic exp_t model(input bit to_f, input int lat);
        exp_t        e;
        int          depth;
        logic [31:0] g, x;
        e.lat = lat; e.err = 0; e.faddr = 0; e.fgot = '0; e.fexp = '0;
        depth = sel ? DB : DA;
        for (int i = 0; i < depth; i++) begin
            g = sel ? {16'h0, mem_b[i]}  : mem_a[i];
            x = sel ? {16'h0, gold_b[i]} : gold_a[i];
            if (g !== x) begin
                if (e.err == 0) begin
                    e.faddr = i; e.fgot = g; e.fexp = x;
                end
                e.err++;
            end
        end
`ifndef ARM_CHECKER_CAPTURE_EN
        e.faddr = 0; e.fgot = '0; e.fexp = '0;
`endif
        e.pass = (e.err == 0) && !to_f;
        e.to   = to_f;
        return e;
    endfunction

    task automatic check_idle(input string p);
        check({p, "_done"},    {63'h0, obs_done},  64'h0);
        check({p, "_pass"},    {63'h0, obs_pass},  64'h0);
        check({p, "_timeout"}, {63'h0, obs_to},    64'h0);
        check({p, "_rd_en"},   {63'h0, obs_rd_en}, 64'h0);
        check({p, "_rd_addr"}, {32'h0, obs_rd_addr}, 64'h0);
        check({p, "_err"},     {32'h0, obs_err},   64'h0);
        check({p, "_faddr"},   {32'h0, obs_faddr}, 64'h0);
        check({p, "_fgot"},    {32'h0, obs_fgot},  64'h0);
        check({p, "_fexp"},    {32'h0, obs_fexp},  64'h0);
    endtask

    task automatic reset_check();
        set_rst(1'b1);
        set_pc(32'h0);
        tick();
        tick();
        check_idle("rst");
        set_rst(1'b0);
    endtask

    task automatic step_pc_to(input logic [31:0] limit);
        logic [31:0] v;
        v = 32'h0;
        set_pc(v);
        while (v < limit) begin
            tick();
            v = v + 32'd4;
            set_pc(v);
        end
    endtask

    task automatic run_sweep();
        int   lat, n, depth;
        bit   seq_ok;
        exp_t e;
        lat = 0; n = 0; seq_ok = 1'b1;
        depth = sel ? DB : DA;
        while (!obs_done && lat < 400) begin
            if (obs_rd_en) begin
                if (obs_rd_addr != 32'(n)) seq_ok = 1'b0;
                n++;
            end
            tick();
            lat++;
        end
        e = sb.pop_front();
        check("latency",   64'(lat),   64'(e.lat));
        check("rd_count",  64'(n),     64'(depth));
        check("addr_seq",  {63'h0, seq_ok}, 64'h1);
        check("done",      {63'h0, obs_done}, 64'h1);
        check("err_count", {32'h0, obs_err},   64'(e.err));
        check("first_addr",{32'h0, obs_faddr}, 64'(e.faddr));
        check("first_got", {32'h0, obs_fgot},  {32'h0, e.fgot});
        check("first_exp", {32'h0, obs_fexp},  {32'h0, e.fexp});
        check("pass",      {63'h0, obs_pass},  {63'h0, e.pass});
        check("timeout",   {63'h0, obs_to},    {63'h0, e.to});
        repeat (3) tick();
        check("done_sticky", {63'h0, obs_done},  64'h1);
        check("rd_en_idle",  {63'h0, obs_rd_en}, 64'h0);
        check("err_stable",  {32'h0, obs_err},   64'(e.err));
    endtask

    task automatic init_a(input logic [31:0] seed);
        for (int i = 0; i < DA; i++) begin
            mem_a[i]  = (32'(i) * 32'h9E37_79B9) ^ seed;
            gold_a[i] = mem_a[i];
        end
    endtask

    initial begin
        int n;
        rst_a = 1'b1; rst_b = 1'b1; pc_a = '0; pc_b = '0; sel = 1'b0;
        init_a(32'h1234_5678);
        for (int i = 0; i < DB; i++) begin
            mem_b[i]  = 16'(i);
            gold_b[i] = ~16'(i);
        end

        // identical memories, pc stepping to END_PC
        reset_check();
        step_pc_to(32'd128);
        sb.push_back(model(1'b0, DA + 2));
        run_sweep();

        // mismatches at words 5 and 63
        init_a(32'hCAFE_0000);
        mem_a[5] = 32'h1; gold_a[5] = 32'h2;
        gold_a[63] = mem_a[63] ^ 32'h8000_0000;
        reset_check();
        step_pc_to(32'd128);
        sb.push_back(model(1'b0, DA + 2));
        run_sweep();

        // watchdog with pc stuck inside imem
        init_a(32'h0BAD_F00D);
        reset_check();
        set_pc(32'h40);
        n = 0;
        while (!obs_to && n < 200) begin
            tick();
            n++;
        end
        check("timeout_cycles", 64'(n), 64'(TO_A));
        sb.push_back(model(1'b1, DA + 1));
        run_sweep();

        // pc reaches END_PC on the watchdog cycle itself
        reset_check();
        set_pc(32'h0);
        repeat (TO_A - 1) tick();
        set_pc(32'd128);
        sb.push_back(model(1'b0, DA + 2));
        run_sweep();

        // reset in the middle of a sweep, then a fresh sweep
        mem_a[10] = mem_a[10] ^ 32'h1;
        reset_check();
        step_pc_to(32'd128);
        n = 0;
        while (!(obs_rd_en && obs_rd_addr == 32'd30) && n < 100) begin
            tick();
            n++;
        end
        check("reach_addr30", {32'h0, obs_rd_addr}, 64'd30);
        set_rst(1'b1);
        set_pc(32'h0);
        tick();
        check_idle("midrst");
        set_rst(1'b0);
        repeat (3) tick();
        check_idle("run_idle");
        set_pc(32'h80);
        sb.push_back(model(1'b0, DA + 2));
        run_sweep();

        // small configuration, every word mismatching
        sel = 1'b1;
        reset_check();
        step_pc_to(32'h40);
        sb.push_back(model(1'b0, DB + 2));
        run_sweep();
        check("addr_hold", {32'h0, obs_rd_addr}, 64'(DB - 1));

        if (sb.size() != 0) check("sb_empty", 64'(sb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
